// File: rtl/simple_proc_pkg.sv
// Shared definitions for the simple processor controller: opcodes, condition
// codes, FSM states and the instruction word layout.
package simple_proc_pkg;

  localparam int unsigned DATA_W    = 16;
  localparam int unsigned INSTR_W   = 32;
  localparam int unsigned REG_IDX_W = 3;
  localparam int unsigned IMM_W     = 7;

  // Bit positions of the instruction fields.
  localparam int unsigned COND_MSB = 31;
  localparam int unsigned COND_LSB = 28;
  localparam int unsigned OPC_MSB  = 27;
  localparam int unsigned OPC_LSB  = 24;
  localparam int unsigned RD_MSB   = 23;
  localparam int unsigned RD_LSB   = 21;
  localparam int unsigned RN_MSB   = 20;
  localparam int unsigned RN_LSB   = 18;
  localparam int unsigned RM_MSB   = 17;
  localparam int unsigned RM_LSB   = 15;
  localparam int unsigned IMM_MSB  = 14;
  localparam int unsigned IMM_LSB  = 8;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_ROR = 4'd10;
  localparam logic [3:0] OP_CMP = 4'd11;
  localparam logic [3:0] OP_ADR = 4'd12;
  localparam logic [3:0] OP_LDR = 4'd13;
  localparam logic [3:0] OP_STR = 4'd14;
  localparam logic [3:0] OP_NOP = 4'd15;

  localparam logic [3:0] CC_EQ = 4'd0;
  localparam logic [3:0] CC_NE = 4'd1;
  localparam logic [3:0] CC_CS = 4'd2;
  localparam logic [3:0] CC_CC = 4'd3;
  localparam logic [3:0] CC_MI = 4'd4;
  localparam logic [3:0] CC_PL = 4'd5;
  localparam logic [3:0] CC_VS = 4'd6;
  localparam logic [3:0] CC_VC = 4'd7;
  localparam logic [3:0] CC_HI = 4'd8;
  localparam logic [3:0] CC_LS = 4'd9;
  localparam logic [3:0] CC_GE = 4'd10;
  localparam logic [3:0] CC_LT = 4'd11;
  localparam logic [3:0] CC_GT = 4'd12;
  localparam logic [3:0] CC_LE = 4'd13;
  localparam logic [3:0] CC_AL = 4'd14;
  localparam logic [3:0] CC_NV = 4'd15;

  typedef enum logic [2:0] {
    ST_FETCH     = 3'd0,
    ST_DECODE    = 3'd1,
    ST_EXECUTE   = 3'd2,
    ST_MEM       = 3'd3,
    ST_WRITEBACK = 3'd4
  } state_e;

  // Upper 24 bits of the instruction word; the low byte carries nothing.
  typedef struct packed {
    logic [3:0]           cond;
    logic [3:0]           opcode;
    logic [REG_IDX_W-1:0] rd;
    logic [REG_IDX_W-1:0] rn;
    logic [REG_IDX_W-1:0] rm;
    logic [IMM_W-1:0]     imm7;
  } instr_t;

  function automatic logic is_mem_op(input logic [3:0] opcode);
    return (opcode == OP_LDR) || (opcode == OP_STR);
  endfunction

  // ALU opcodes whose registered result is written back to Rd.
  function automatic logic writes_alu_result(input logic [3:0] opcode);
    return (opcode <= OP_ROR) || (opcode == OP_ADR);
  endfunction

endpackage

// File: rtl/simple_proc_ctrl_cond_eval.sv
// Combinational condition-code evaluator: decides whether an instruction
// executes given its cond field and the ALU's N/Z/C/V flags.
module simple_proc_ctrl_cond_eval
  import simple_proc_pkg::*;
(
  input  logic [3:0] cond,
  input  logic       flag_n,
  input  logic       flag_z,
  input  logic       flag_c,
  input  logic       flag_v,
  output logic       pass
);

  always_comb begin
    pass = 1'b0;
    case (cond)
      CC_EQ: pass = flag_z;
      CC_NE: pass = !flag_z;
      CC_CS: pass = flag_c;
      CC_CC: pass = !flag_c;
      CC_MI: pass = flag_n;
      CC_PL: pass = !flag_n;
      CC_VS: pass = flag_v;
      CC_VC: pass = !flag_v;
      CC_HI: pass = flag_c && !flag_z;
      CC_LS: pass = !flag_c || flag_z;
      CC_GE: pass = (flag_n == flag_v);
      CC_LT: pass = (flag_n != flag_v);
      CC_GT: pass = !flag_z && (flag_n == flag_v);
      CC_LE: pass = flag_z || (flag_n != flag_v);
      CC_AL: pass = 1'b1;
      CC_NV: pass = 1'b0;
      default: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/simple_proc_ctrl.sv
// Instruction sequencer/decoder for the 16-bit simple processor: fetch,
// decode, execute via the external ALU, optional data access, writeback.
module simple_proc_ctrl
  import simple_proc_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int unsigned NUM_REGS = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [15:0] dmem_addr,
  output logic [15:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [15:0] dmem_rdata,
  output logic [3:0]  alu_opcode,
  output logic [15:0] alu_operand_1,
  output logic [15:0] alu_operand_2,
  output logic [6:0]  alu_immediate,
  output logic        alu_condition_success,
  input  logic [15:0] alu_result,
  input  logic        alu_negative,
  input  logic        alu_zero,
  input  logic        alu_carry,
  input  logic        alu_overflow,
  output logic [15:0] pc,
  output logic        retire,
  output logic        cond_fail
);

  // Memory handshakes: req rises in the owning state and is held with
  // address/data stable until ack is sampled high on a rising edge while req
  // is high; ack with req low is ignored. Load data is valid in the ack cycle.

  state_e        state_q, state_d;
  logic [15:0]   pc_q, pc_d;
  instr_t        instr_q, instr_d;
  logic [15:0]   rn_val_q, rn_val_d;
  logic [15:0]   rm_val_q, rm_val_d;
  logic [15:0]   rd_val_q, rd_val_d;
  logic [15:0]   load_q, load_d;
  logic          pass_q, pass_d;
  logic [15:0]   regs_q [NUM_REGS];
  logic [15:0]   regs_d [NUM_REGS];

  logic          imem_req_q, imem_req_d;
  logic          dmem_req_q, dmem_req_d;
  logic          dmem_we_q, dmem_we_d;
  logic [15:0]   dmem_addr_q, dmem_addr_d;
  logic [15:0]   dmem_wdata_q, dmem_wdata_d;
  logic [3:0]    alu_opcode_q, alu_opcode_d;
  logic          alu_cs_q, alu_cs_d;
  logic          retire_q, retire_d;
  logic          cond_fail_q, cond_fail_d;

  logic          cond_pass;
  logic          wb_en;
  logic [15:0]   wb_data;
  logic          unused_low_byte;

  assign unused_low_byte = ^imem_rdata[7:0];

  simple_proc_ctrl_cond_eval u_cond_eval (
    .cond   (instr_q.cond),
    .flag_n (alu_negative),
    .flag_z (alu_zero),
    .flag_c (alu_carry),
    .flag_v (alu_overflow),
    .pass   (cond_pass)
  );

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    instr_d      = instr_q;
    rn_val_d     = rn_val_q;
    rm_val_d     = rm_val_q;
    rd_val_d     = rd_val_q;
    load_d       = load_q;
    pass_d       = pass_q;
    dmem_addr_d  = dmem_addr_q;
    dmem_wdata_d = dmem_wdata_q;

    case (state_q)
      ST_FETCH: begin
        if (imem_req_q && imem_ack) begin
          instr_d = instr_t'(imem_rdata[31:8]);
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        rn_val_d = regs_q[instr_q.rn];
        rm_val_d = regs_q[instr_q.rm];
        rd_val_d = regs_q[instr_q.rd];
        pass_d   = cond_pass;
        state_d  = ST_EXECUTE;
      end
      ST_EXECUTE: begin
        if (pass_q && is_mem_op(instr_q.opcode)) begin
          dmem_addr_d  = rn_val_q + {9'b0, instr_q.imm7};
          dmem_wdata_d = rd_val_q;
          state_d      = ST_MEM;
        end else begin
          state_d = ST_WRITEBACK;
        end
      end
      ST_MEM: begin
        if (dmem_req_q && dmem_ack) begin
          if (!dmem_we_q) begin
            load_d = dmem_rdata;
          end
          state_d = ST_WRITEBACK;
        end
      end
      ST_WRITEBACK: begin
        pc_d    = pc_q + 16'd1;
        state_d = ST_FETCH;
      end
      default: state_d = ST_FETCH;
    endcase

    // Outputs are registered from the next state so they line up with it.
    imem_req_d   = (state_d == ST_FETCH);
    dmem_req_d   = (state_d == ST_MEM);
    dmem_we_d    = (state_d == ST_MEM) && (instr_q.opcode == OP_STR);
    alu_opcode_d = (state_d == ST_EXECUTE) ? instr_q.opcode : OP_NOP;
    alu_cs_d     = (state_d == ST_EXECUTE) && pass_d;
    retire_d     = (state_d == ST_WRITEBACK);
    cond_fail_d  = (state_d == ST_WRITEBACK) && !pass_d;
  end

  always_comb begin
    wb_en   = 1'b0;
    wb_data = alu_result;
    if ((state_q == ST_WRITEBACK) && pass_q) begin
      if (instr_q.opcode == OP_LDR) begin
        wb_en   = 1'b1;
        wb_data = load_q;
      end else if (writes_alu_result(instr_q.opcode)) begin
        wb_en = 1'b1;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      regs_d[i] = regs_q[i];
    end
    if (wb_en) begin
      regs_d[instr_q.rd] = wb_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_FETCH;
      pc_q         <= RESET_PC;
      instr_q      <= '0;
      rn_val_q     <= '0;
      rm_val_q     <= '0;
      rd_val_q     <= '0;
      load_q       <= '0;
      pass_q       <= 1'b0;
      imem_req_q   <= 1'b0;
      dmem_req_q   <= 1'b0;
      dmem_we_q    <= 1'b0;
      dmem_addr_q  <= '0;
      dmem_wdata_q <= '0;
      alu_opcode_q <= OP_NOP;
      alu_cs_q     <= 1'b0;
      retire_q     <= 1'b0;
      cond_fail_q  <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      instr_q      <= instr_d;
      rn_val_q     <= rn_val_d;
      rm_val_q     <= rm_val_d;
      rd_val_q     <= rd_val_d;
      load_q       <= load_d;
      pass_q       <= pass_d;
      imem_req_q   <= imem_req_d;
      dmem_req_q   <= dmem_req_d;
      dmem_we_q    <= dmem_we_d;
      dmem_addr_q  <= dmem_addr_d;
      dmem_wdata_q <= dmem_wdata_d;
      alu_opcode_q <= alu_opcode_d;
      alu_cs_q     <= alu_cs_d;
      retire_q     <= retire_d;
      cond_fail_q  <= cond_fail_d;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  assign imem_req              = imem_req_q;
  assign imem_addr             = pc_q;
  assign pc                    = pc_q;
  assign dmem_req              = dmem_req_q;
  assign dmem_we               = dmem_we_q;
  assign dmem_addr             = dmem_addr_q;
  assign dmem_wdata            = dmem_wdata_q;
  assign alu_opcode            = alu_opcode_q;
  assign alu_operand_1         = rn_val_q;
  assign alu_operand_2         = rm_val_q;
  assign alu_immediate         = instr_q.imm7;
  assign alu_condition_success = alu_cs_q;
  assign retire                = retire_q;
  assign cond_fail             = cond_fail_q;

endmodule

// File: tb/tb_simple_proc_ctrl.sv
// Directed bench for simple_proc_ctrl: drives fetch/data memory and a tiny
// ALU stand-in, and checks timing, decode, writeback and condition handling.
module tb_simple_proc_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req, imem_ack;
  logic [15:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [15:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  alu_opcode;
  logic [15:0] alu_operand_1, alu_operand_2, alu_result;
  logic [6:0]  alu_immediate;
  logic        alu_condition_success;
  logic        alu_negative, alu_zero, alu_carry, alu_overflow;
  logic [15:0] pc;
  logic        retire, cond_fail;

  // Second instance, reset to the top of the address space.
  logic        w_rst_n, w_imem_ack, w_dmem_ack;
  logic        w_imem_req, w_dmem_req, w_dmem_we, w_alu_cs, w_retire, w_cond_fail;
  logic [15:0] w_imem_addr, w_dmem_addr, w_dmem_wdata, w_op1, w_op2, w_pc;
  logic [3:0]  w_alu_opcode;
  logic [6:0]  w_alu_imm;

  int errors = 0;
  int checks = 0;
  logic [15:0] exp_pc;

  int          obs_retire_cyc, obs_acs_mask, obs_mem_cycles;
  logic        obs_cond_fail, obs_dwe, obs_dstable;
  logic [3:0]  obs_exec_opcode;
  logic [15:0] obs_op1, obs_op2, obs_daddr, obs_dwdata, obs_fetch_addr, obs_pc_after;

  always #5 clk = ~clk;

  simple_proc_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .alu_opcode(alu_opcode), .alu_operand_1(alu_operand_1), .alu_operand_2(alu_operand_2),
    .alu_immediate(alu_immediate), .alu_condition_success(alu_condition_success),
    .alu_result(alu_result), .alu_negative(alu_negative), .alu_zero(alu_zero),
    .alu_carry(alu_carry), .alu_overflow(alu_overflow),
    .pc(pc), .retire(retire), .cond_fail(cond_fail)
  );

  simple_proc_ctrl #(.RESET_PC(16'hFFFF)) dut_wrap (
    .clk(clk), .rst_n(w_rst_n),
    .imem_req(w_imem_req), .imem_addr(w_imem_addr), .imem_ack(w_imem_ack), .imem_rdata(imem_rdata),
    .dmem_req(w_dmem_req), .dmem_we(w_dmem_we), .dmem_addr(w_dmem_addr), .dmem_wdata(w_dmem_wdata),
    .dmem_ack(w_dmem_ack), .dmem_rdata(dmem_rdata),
    .alu_opcode(w_alu_opcode), .alu_operand_1(w_op1), .alu_operand_2(w_op2),
    .alu_immediate(w_alu_imm), .alu_condition_success(w_alu_cs),
    .alu_result(alu_result), .alu_negative(alu_negative), .alu_zero(alu_zero),
    .alu_carry(alu_carry), .alu_overflow(alu_overflow),
    .pc(w_pc), .retire(w_retire), .cond_fail(w_cond_fail)
  );

  function automatic logic [31:0] enc(input logic [3:0] cc, input logic [3:0] op,
                                      input logic [2:0] rd, input logic [2:0] rn,
                                      input logic [2:0] rm, input logic [6:0] imm);
    return {cc, op, rd, rn, rm, imm, 8'hA5};
  endfunction

  function automatic logic cond_ref(input logic [3:0] cc, input logic n, input logic z,
                                    input logic c, input logic v);
    case (cc)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return c;
      4'd3:  return !c;
      4'd4:  return n;
      4'd5:  return !n;
      4'd6:  return v;
      4'd7:  return !v;
      4'd8:  return c && !z;
      4'd9:  return !c || z;
      4'd10: return n == v;
      4'd11: return n != v;
      4'd12: return !z && (n == v);
      4'd13: return z || (n != v);
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Runs one instruction on the main instance, recording what it drove.
  task automatic run_instr(input logic [31:0] instr, input int dwait, input logic [15:0] ldata);
    int n;
    int cyc;
    int waited;
    obs_retire_cyc = 0; obs_acs_mask = 0; obs_mem_cycles = 0; obs_cond_fail = 1'bx;
    obs_exec_opcode = 4'hF; obs_dstable = 1'b1; obs_dwe = 1'bx;
    obs_daddr = 'x; obs_dwdata = 'x; obs_op1 = 'x; obs_op2 = 'x;
    n = 0;
    while (imem_req !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (imem_req !== 1'b1) begin
      checks++; errors++;
      $display("FAIL fetch_timeout: imem_req=%b required 1", imem_req);
      return;
    end
    obs_fetch_addr = imem_addr;
    imem_rdata = instr;
    imem_ack = 1'b1;
    cyc = 1;
    waited = 0;
    while (cyc < 30) begin
      @(negedge clk);
      cyc++;
      imem_ack = 1'b0;
      dmem_ack = 1'b0;
      if (alu_condition_success === 1'b1) obs_acs_mask |= (1 << cyc);
      if (alu_opcode !== 4'hF) begin
        obs_exec_opcode = alu_opcode;
        obs_op1 = alu_operand_1;
        obs_op2 = alu_operand_2;
        alu_result = (alu_opcode == 4'd0) ? (alu_operand_1 + alu_operand_2) : 16'hDEAD;
      end
      if (dmem_req === 1'b1) begin
        if (obs_mem_cycles == 0) begin
          obs_daddr = dmem_addr; obs_dwdata = dmem_wdata; obs_dwe = dmem_we;
        end else if (dmem_addr !== obs_daddr || dmem_wdata !== obs_dwdata || dmem_we !== obs_dwe) begin
          obs_dstable = 1'b0;
        end
        obs_mem_cycles++;
        if (waited >= dwait) begin
          dmem_ack = 1'b1;
          dmem_rdata = ldata;
        end
        waited++;
      end
      if (retire === 1'b1) begin
        obs_retire_cyc = cyc;
        obs_cond_fail = cond_fail;
        break;
      end
    end
    if (obs_retire_cyc == 0) begin
      checks++; errors++;
      $display("FAIL retire_timeout: no retire within %0d cycles", cyc);
      return;
    end
    @(negedge clk);
    obs_pc_after = pc;
    exp_pc = exp_pc + 16'd1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_imem_req: got %b required 0", imem_req); end
    checks++; if (dmem_req !== 1'b0) begin errors++; $display("FAIL rst_dmem_req: got %b required 0", dmem_req); end
    checks++; if (dmem_we !== 1'b0) begin errors++; $display("FAIL rst_dmem_we: got %b required 0", dmem_we); end
    checks++; if (retire !== 1'b0 || cond_fail !== 1'b0) begin errors++; $display("FAIL rst_retire: got %b/%b required 0/0", retire, cond_fail); end
    checks++; if (alu_condition_success !== 1'b0) begin errors++; $display("FAIL rst_alu_cs: got %b required 0", alu_condition_success); end
    checks++; if (alu_opcode !== 4'hF) begin errors++; $display("FAIL rst_alu_opcode: got %h required f", alu_opcode); end
    checks++; if (pc !== 16'h0000 || imem_addr !== 16'h0000) begin errors++; $display("FAIL rst_pc: got %h/%h required 0000", pc, imem_addr); end
    checks++; if (alu_operand_1 !== 16'h0 || alu_operand_2 !== 16'h0 || alu_immediate !== 7'h0) begin
      errors++; $display("FAIL rst_operands: got %h %h %h required 0", alu_operand_1, alu_operand_2, alu_immediate);
    end
    checks++; if (dmem_addr !== 16'h0 || dmem_wdata !== 16'h0) begin errors++; $display("FAIL rst_dmem_bus: got %h/%h required 0", dmem_addr, dmem_wdata); end
    rst_n = 1'b1;
    exp_pc = 16'h0000;
  endtask

  task automatic test_ldr();
    run_instr(enc(4'd14, 4'd13, 3'd6, 3'd0, 3'd0, 7'd10), 0, 16'h1234);
    checks++; if (obs_fetch_addr !== 16'h0000) begin errors++; $display("FAIL ldr_first_fetch: got %h required 0000", obs_fetch_addr); end
    checks++; if (obs_retire_cyc !== 5) begin errors++; $display("FAIL ldr_retire_cycle: got %0d required 5", obs_retire_cyc); end
    checks++; if (obs_daddr !== 16'h000A || obs_dwe !== 1'b0) begin errors++; $display("FAIL ldr_dmem: got addr %h we %b required 000a 0", obs_daddr, obs_dwe); end
    checks++; if (obs_pc_after !== 16'h0001) begin errors++; $display("FAIL ldr_pc: got %h required 0001", obs_pc_after); end
    run_instr(enc(4'd14, 4'd13, 3'd2, 3'd0, 3'd0, 7'd0), 0, 16'd5);
    run_instr(enc(4'd14, 4'd13, 3'd3, 3'd0, 3'd0, 7'd1), 0, 16'd7);
    run_instr(enc(4'd14, 4'd14, 3'd6, 3'd0, 3'd0, 7'd0), 0, 16'h0);
    checks++; if (obs_dwdata !== 16'h1234 || obs_dwe !== 1'b1) begin errors++; $display("FAIL ldr_r6_value: got %h we %b required 1234 1", obs_dwdata, obs_dwe); end
  endtask

  task automatic test_add();
    run_instr(enc(4'd14, 4'd0, 3'd1, 3'd2, 3'd3, 7'd9), 0, 16'h0);
    checks++; if (obs_retire_cyc !== 4) begin errors++; $display("FAIL add_retire_cycle: got %0d required 4", obs_retire_cyc); end
    checks++; if (obs_acs_mask !== (1 << 3)) begin errors++; $display("FAIL add_cs_window: got %h required 8", obs_acs_mask); end
    checks++; if (obs_exec_opcode !== 4'd0 || obs_op1 !== 16'd5 || obs_op2 !== 16'd7) begin
      errors++; $display("FAIL add_operands: got op %h %h %h required 0 0005 0007", obs_exec_opcode, obs_op1, obs_op2);
    end
    checks++; if (obs_cond_fail !== 1'b0) begin errors++; $display("FAIL add_cond_fail: got %b required 0", obs_cond_fail); end
    checks++; if (obs_pc_after !== exp_pc) begin errors++; $display("FAIL add_pc: got %h required %h", obs_pc_after, exp_pc); end
    run_instr(enc(4'd14, 4'd14, 3'd1, 3'd0, 3'd0, 7'd0), 0, 16'h0);
    checks++; if (obs_dwdata !== 16'd12) begin errors++; $display("FAIL add_r1_value: got %h required 000c", obs_dwdata); end
  endtask

  task automatic test_cond_fail();
    alu_zero = 1'b1;
    run_instr(enc(4'd1, 4'd0, 3'd7, 3'd2, 3'd3, 7'd0), 0, 16'h0);
    checks++; if (obs_cond_fail !== 1'b1) begin errors++; $display("FAIL ne_cond_fail: got %b required 1", obs_cond_fail); end
    checks++; if (obs_acs_mask !== 0) begin errors++; $display("FAIL ne_cs_window: got %h required 0", obs_acs_mask); end
    checks++; if (obs_retire_cyc !== 4) begin errors++; $display("FAIL ne_retire_cycle: got %0d required 4", obs_retire_cyc); end
    run_instr(enc(4'd14, 4'd14, 3'd7, 3'd0, 3'd0, 7'd0), 0, 16'h0);
    checks++; if (obs_dwdata !== 16'h0000) begin errors++; $display("FAIL ne_rd_unchanged: got %h required 0000", obs_dwdata); end
    alu_zero = 1'b0;
  endtask

  task automatic test_cond_sweep();
    logic exp_pass;
    for (int f = 0; f < 16; f++) begin
      for (int c = 0; c < 16; c++) begin
        {alu_negative, alu_zero, alu_carry, alu_overflow} = f[3:0];
        exp_pass = cond_ref(c[3:0], f[3], f[2], f[1], f[0]);
        run_instr(enc(c[3:0], 4'd15, 3'd0, 3'd0, 3'd0, 7'd0), 0, 16'h0);
        checks++;
        if (obs_cond_fail !== !exp_pass) begin
          errors++;
          $display("FAIL cond_sweep cc=%0d nzcv=%b: got cond_fail %b required %b", c, f[3:0], obs_cond_fail, !exp_pass);
        end
      end
    end
    {alu_negative, alu_zero, alu_carry, alu_overflow} = 4'b0000;
  endtask

  task automatic test_str_wait();
    run_instr(enc(4'd14, 4'd13, 3'd5, 3'd0, 3'd0, 7'd2), 0, 16'hFFFE);
    run_instr(enc(4'd14, 4'd13, 3'd4, 3'd0, 3'd0, 7'd3), 0, 16'hA5A5);
    run_instr(enc(4'd14, 4'd14, 3'd4, 3'd5, 3'd0, 7'd3), 3, 16'h0);
    checks++; if (obs_daddr !== 16'h0001) begin errors++; $display("FAIL str_addr_wrap: got %h required 0001", obs_daddr); end
    checks++; if (obs_dwe !== 1'b1 || obs_dwdata !== 16'hA5A5) begin errors++; $display("FAIL str_we_wdata: got %b %h required 1 a5a5", obs_dwe, obs_dwdata); end
    checks++; if (obs_dstable !== 1'b1) begin errors++; $display("FAIL str_stable: got %b required 1", obs_dstable); end
    checks++; if (obs_mem_cycles !== 4) begin errors++; $display("FAIL str_req_cycles: got %0d required 4", obs_mem_cycles); end
    checks++; if (obs_retire_cyc !== 8) begin errors++; $display("FAIL str_retire_cycle: got %0d required 8", obs_retire_cyc); end
  endtask

  task automatic test_mem_reset();
    int n;
    logic saw_bad;
    n = 0;
    while (imem_req !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    imem_rdata = enc(4'd14, 4'd13, 3'd2, 3'd0, 3'd0, 7'd0);
    imem_ack = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      imem_ack = 1'b0;
      n++;
    end while (dmem_req !== 1'b1 && n < 40);
    checks++; if (dmem_req !== 1'b1) begin errors++; $display("FAIL mrst_reach_mem: got %b required 1", dmem_req); end
    #1 rst_n = 1'b0;
    #1;
    checks++; if (dmem_req !== 1'b0) begin errors++; $display("FAIL mrst_req_drop: got %b required 0", dmem_req); end
    checks++; if (pc !== 16'h0000) begin errors++; $display("FAIL mrst_pc: got %h required 0000", pc); end
    dmem_rdata = 16'hBEEF;
    dmem_ack = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    saw_bad = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (retire !== 1'b0 || dmem_req !== 1'b0) saw_bad = 1'b1;
    end
    dmem_ack = 1'b0;
    checks++; if (saw_bad !== 1'b0) begin errors++; $display("FAIL mrst_late_ack: got activity %b required 0", saw_bad); end
    exp_pc = 16'h0000;
    run_instr(enc(4'd14, 4'd14, 3'd2, 3'd0, 3'd0, 7'd0), 0, 16'h0);
    checks++; if (obs_fetch_addr !== 16'h0000) begin errors++; $display("FAIL mrst_refetch: got %h required 0000", obs_fetch_addr); end
    checks++; if (obs_dwdata !== 16'h0000) begin errors++; $display("FAIL mrst_regs_cleared: got %h required 0000", obs_dwdata); end
    checks++; if (obs_pc_after !== 16'h0001) begin errors++; $display("FAIL mrst_pc_after: got %h required 0001", obs_pc_after); end
  endtask

  task automatic test_pc_wrap();
    int n;
    w_rst_n = 1'b1;
    n = 0;
    while (w_imem_req !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++; if (w_imem_addr !== 16'hFFFF || w_pc !== 16'hFFFF) begin errors++; $display("FAIL wrap_start: got %h/%h required ffff", w_imem_addr, w_pc); end
    imem_rdata = enc(4'd14, 4'd15, 3'd0, 3'd0, 3'd0, 7'd0);
    w_imem_ack = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      w_imem_ack = 1'b0;
      n++;
    end while (w_retire !== 1'b1 && n < 40);
    checks++; if (w_retire !== 1'b1 || n !== 3) begin errors++; $display("FAIL wrap_retire: got %b after %0d cycles required 1 after 3", w_retire, n); end
    @(negedge clk);
    checks++; if (w_pc !== 16'h0000 || w_imem_addr !== 16'h0000) begin errors++; $display("FAIL wrap_pc: got %h/%h required 0000", w_pc, w_imem_addr); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; w_rst_n = 1'b0;
    imem_ack = 1'b0; imem_rdata = '0; dmem_ack = 1'b0; dmem_rdata = '0;
    w_imem_ack = 1'b0; w_dmem_ack = 1'b0;
    alu_result = '0;
    {alu_negative, alu_zero, alu_carry, alu_overflow} = 4'b0000;
    exp_pc = 16'h0000;
    @(negedge clk);
    test_reset();
    test_ldr();
    test_add();
    test_cond_fail();
    test_cond_sweep();
    test_str_wait();
    test_mem_reset();
    test_pc_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
